pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 122 ++++++++++++
 tb/tb_pipe_adder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Purpose : pipelined WIDTH-bit adder/subtractor; one WIDTH/STAGES-bit chunk is summed per stage.
// Latency : STAGES cycles, so a result is on the outputs after edge n+STAGES-1 for an op accepted at edge n.
// Backpr. : valid/ready; the whole pipe advances together and freezes while the output is held.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     operation handshake (a_i, b_i, carry_i, sub_i)
//   valid_o / ready_i     result handshake (sum_o, carry_o, overflow_o, zero_o)
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);
    localparam int C_SAFE_S = (STAGES > 0) ? STAGES : 1;
    localparam int C        = WIDTH / C_SAFE_S;

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % C_SAFE_S) != 0)) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Per-stage state. r_a/r_b carry the whole operand (b already conditioned
    // for subtract) so the unconsumed chunks and the sign bits needed for
    // overflow stay with their own operation; r_sum collects finished chunks.
    logic             r_vld [STAGES];
    logic             r_cy  [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];

    logic             w_n_vld [STAGES];
    logic             w_n_cy  [STAGES];
    logic [WIDTH-1:0] w_n_a   [STAGES];
    logic [WIDTH-1:0] w_n_b   [STAGES];
    logic [WIDTH-1:0] w_n_sum [STAGES];

    logic [WIDTH-1:0] w_bp;
    logic             w_cin;
    logic [C:0]       w_add;
    logic             w_adv;

    // Single global enable: everything moves when the output slot is free
    // or being drained this cycle.
    assign w_adv   = !r_vld[STAGES-1] || ready_i;
    assign ready_o = w_adv;

    always_comb begin
        w_bp  = sub_i ? ~b_i : b_i;
        w_cin = sub_i ? 1'b1 : carry_i;
        for (int k = 0; k < STAGES; k++) begin
            w_n_vld[k] = 1'b0;
            w_n_cy[k]  = 1'b0;
            w_n_a[k]   = '0;
            w_n_b[k]   = '0;
            w_n_sum[k] = '0;
        end

        // Stage 0 sums the lowest chunk straight from the inputs.
        w_add               = {1'b0, a_i[C-1:0]} + {1'b0, w_bp[C-1:0]} + {{C{1'b0}}, w_cin};
        w_n_vld[0]          = valid_i;
        w_n_a[0]            = a_i;
        w_n_b[0]            = w_bp;
        w_n_sum[0][C-1:0]   = w_add[C-1:0];
        w_n_cy[0]           = w_add[C];

        // Stage k sums chunk k from the previous stage's register and ripple carry.
        for (int k = 1; k < STAGES; k++) begin
            w_add = {1'b0, r_a[k-1][k*C +: C]} + {1'b0, r_b[k-1][k*C +: C]}
                  + {{C{1'b0}}, r_cy[k-1]};
            w_n_vld[k]            = r_vld[k-1];
            w_n_a[k]              = r_a[k-1];
            w_n_b[k]              = r_b[k-1];
            w_n_sum[k]            = r_sum[k-1];
            w_n_sum[k][k*C +: C]  = w_add[C-1:0];
            w_n_cy[k]             = w_add[C];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_cy[k]  <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_n_vld[k];
                r_cy[k]  <= w_n_cy[k];
                r_a[k]   <= w_n_a[k];
                r_b[k]   <= w_n_b[k];
                r_sum[k] <= w_n_sum[k];
            end
        end
    end

    assign valid_o    = r_vld[STAGES-1];
    assign sum_o      = r_sum[STAGES-1];
    assign carry_o    = r_cy[STAGES-1];
    // Signed overflow: operands (with b conditioned) agree in sign, result does not.
    assign overflow_o = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
                     && (r_sum[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
    assign zero_o     = (r_sum[STAGES-1] == '0);

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;
    localparam int W = 32;
    localparam int S = 4;

    typedef logic [W+1:0] res_t;  // {overflow, carry, sum}

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i, ready_o, carry_i, sub_i, valid_o, ready_i;
    logic [W-1:0] a_i, b_i, sum_o;
    logic         carry_o, overflow_o, zero_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
        .carry_o(carry_o), .overflow_o(overflow_o), .zero_o(zero_o)
    );

    function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub);
        logic [W-1:0] bp;
        logic [W:0]   full;
        logic         ovf;
        bp   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full};
    endfunction

    // Drives one cycle of inputs at the falling edge and records the handshakes
    // that will complete at the next rising edge; callers do the comparing.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic rdy,
                        output logic popped, output logic pushed, output logic unexp,
                        output res_t exp);
        @(negedge clk);
        valid_i = v; a_i = a; b_i = b; carry_i = cin; sub_i = sub; ready_i = rdy;
        #1;
        popped = 1'b0; pushed = 1'b0; unexp = 1'b0; exp = '0;
        if (valid_o && ready_i) begin
            popped = 1'b1;
            if (sb.size() == 0) unexp = 1'b1;
            else exp = sb.pop_front();
        end
        if (valid_i && ready_o && !rst) begin
            pushed = 1'b1;
            sb.push_back(ref_add(a, b, cin, sub));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
        n_checks++; if (sum_o !== '0) begin n_fail++; $display("FAIL reset_sum_o: got %h want 0", sum_o); end
        n_checks++; if (carry_o !== 1'b0) begin n_fail++; $display("FAIL reset_carry_o: got %b want 0", carry_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow_o: got %b want 0", overflow_o); end
        n_checks++; if (zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero_o: got %b want 1", zero_o); end
    endtask

    task automatic test_directed();
        // a, b, cin, sub, expected sum, carry, overflow, zero
        logic [W-1:0] ta [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0005};
        logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0003};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         tsb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] es [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0002};
        logic         ec [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         eo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic         ez [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic popped, pushed, unexp;
        res_t exp;
        for (int t = 0; t < 5; t++) begin
            int lat = -1;
            step(1'b1, ta[t], tb[t], tc[t], tsb[t], 1'b1, popped, pushed, unexp, exp);
            for (int i = 1; i <= 20 && lat < 0; i++) begin
                step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
                if (popped) begin
                    lat = i;
                    n_checks++;
                    if ({overflow_o, carry_o, sum_o} !== {eo[t], ec[t], es[t]}) begin
                        n_fail++;
                        $display("FAIL directed%0d_result: got ovf=%b cy=%b sum=%h want ovf=%b cy=%b sum=%h",
                                 t, overflow_o, carry_o, sum_o, eo[t], ec[t], es[t]);
                    end
                    n_checks++;
                    if (zero_o !== ez[t]) begin n_fail++; $display("FAIL directed%0d_zero: got %b want %b", t, zero_o, ez[t]); end
                end
            end
            n_checks++;
            if (lat != S) begin n_fail++; $display("FAIL directed%0d_latency: got %0d want %0d", t, lat, S); end
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0, gaps = 0, first = -1, last = -1, unexp_n = 0;
        logic popped, pushed, unexp;
        res_t exp;
        for (int i = 0; i < 200 && pops < 100; i++) begin
            logic [W-1:0] a, b;
            logic cin, sub;
            a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            step(i < 100, a, b, cin, sub, 1'b1, popped, pushed, unexp, exp);
            if (unexp) unexp_n++;
            else if (popped) begin
                n_checks++;
                if ({overflow_o, carry_o, sum_o} !== exp || zero_o !== (exp[W-1:0] == '0)) begin
                    n_fail++;
                    $display("FAIL b2b_result: got %h z=%b want %h", {overflow_o, carry_o, sum_o}, zero_o, exp);
                end
            end
            if (popped) begin
                if (first < 0) first = i;
                else if (i != last + 1) gaps++;
                last = i;
                pops++;
            end
        end
        n_checks++; if (pops != 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", pops); end
        n_checks++; if (gaps != 0 || unexp_n != 0) begin n_fail++; $display("FAIL b2b_gaps: got gaps=%0d extra=%0d want 0 0", gaps, unexp_n); end
        n_checks++; if (first != S) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", first, S); end
    endtask

    task automatic test_random_stall();
        int acc = 0, unexp_n = 0, cyc = 0;
        logic popped, pushed, unexp, v, rdy, cin, sub, prev_stall, held_zero;
        logic [W-1:0] a, b;
        res_t exp, obs, held;
        prev_stall = 1'b0; held = '0; held_zero = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            v = 1'($urandom_range(0, 1)); rdy = 1'($urandom_range(0, 1));
            a = $urandom(); b = $urandom(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            step(v, a, b, cin, sub, rdy, popped, pushed, unexp, exp);
            cyc++;
            obs = {overflow_o, carry_o, sum_o};
            if (prev_stall) begin
                n_checks++;
                if (valid_o !== 1'b1 || obs !== held || zero_o !== held_zero) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b %h z=%b want v=1 %h z=%b", valid_o, obs, zero_o, held, held_zero);
                end
            end
            prev_stall = valid_o && !ready_i;
            held = obs; held_zero = zero_o;
            if (unexp) unexp_n++;
            else if (popped) begin
                n_checks++;
                if (obs !== exp || zero_o !== (exp[W-1:0] == '0)) begin
                    n_fail++;
                    $display("FAIL random_result: got %h z=%b want %h", obs, zero_o, exp);
                end
            end
            if (pushed) acc++;
        end
        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
            if (unexp) unexp_n++;
            else if (popped) begin
                n_checks++;
                if ({overflow_o, carry_o, sum_o} !== exp) begin
                    n_fail++;
                    $display("FAIL drain_result: got %h want %h", {overflow_o, carry_o, sum_o}, exp);
                end
            end
        end
        n_checks++; if (acc != 10000) begin n_fail++; $display("FAIL random_accepted: got %0d want 10000", acc); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL random_lost: got %0d pending want 0", sb.size()); end
        n_checks++; if (unexp_n != 0) begin n_fail++; $display("FAIL random_extra: got %0d want 0", unexp_n); end
    endtask

    task automatic test_reset_in_flight();
        int seen = 0, lat = -1;
        logic popped, pushed, unexp;
        res_t exp;
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
        @(negedge clk);
        rst = 1'b1; valid_i = 1'b1; a_i = 32'h1111_1111; b_i = 32'h2222_2222; ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; valid_i = 1'b0;
        #1;
        sb.delete();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid_o: got %b want 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready_o: got %b want 1", ready_o); end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
            if (valid_o) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_ghosts: got %0d want 0", seen); end
        step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, popped, pushed, unexp, exp);
            if (popped) begin
                lat = i;
                n_checks++;
                if ({overflow_o, carry_o, sum_o} !== {2'b00, 32'h2345_6789} || unexp) begin
                    n_fail++;
                    $display("FAIL flush_next_op: got %h want %h", {overflow_o, carry_o, sum_o}, {2'b00, 32'h2345_6789});
                end
            end
        end
        n_checks++; if (lat != S) begin n_fail++; $display("FAIL flush_latency: got %0d want %0d", lat, S); end
    endtask

    // Additional geometries, each streamed back-to-back.
    localparam int NCFG = 4;
    localparam int CFG_W [NCFG] = '{32, 32, 8, 64};
    localparam int CFG_S [NCFG] = '{1, 32, 2, 8};

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int CW = CFG_W[gi];
            localparam int CS = CFG_S[gi];
            logic          c_valid_i = 1'b0;
            logic          c_ready_i = 1'b1;
            logic          c_carry_i = 1'b0;
            logic          c_sub_i   = 1'b0;
            logic [CW-1:0] c_a_i     = '0;
            logic [CW-1:0] c_b_i     = '0;
            logic          c_ready_o, c_valid_o, c_carry_o, c_overflow_o, c_zero_o;
            logic [CW-1:0] c_sum_o;
            logic [CW+1:0] c_sb[$];

            pipe_adder #(.WIDTH(CW), .STAGES(CS)) u_dut (
                .clk_i(clk), .rst_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o),
                .a_i(c_a_i), .b_i(c_b_i), .carry_i(c_carry_i), .sub_i(c_sub_i),
                .valid_o(c_valid_o), .ready_i(c_ready_i), .sum_o(c_sum_o),
                .carry_o(c_carry_o), .overflow_o(c_overflow_o), .zero_o(c_zero_o)
            );

            function automatic logic [CW+1:0] c_ref(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                                    input logic cin, input logic sub);
                logic [CW-1:0] bp;
                logic [CW:0]   full;
                logic          ovf;
                bp   = sub ? ~b : b;
                full = {1'b0, a} + {1'b0, bp} + {{CW{1'b0}}, (sub ? 1'b1 : cin)};
                ovf  = (a[CW-1] == bp[CW-1]) && (full[CW-1] != a[CW-1]);
                return {ovf, full};
            endfunction

            task automatic test_b2b_cfg();
                int pops = 0, gaps = 0, first = -1, last = -1, unexp_n = 0;
                logic [63:0]   r64a, r64b;
                logic [CW+1:0] exp;
                for (int i = 0; i < 100 + CS + 20 && pops < 100; i++) begin
                    @(negedge clk);
                    r64a = {$urandom(), $urandom()};
                    r64b = {$urandom(), $urandom()};
                    c_valid_i = (i < 100); c_ready_i = 1'b1;
                    c_a_i = r64a[CW-1:0]; c_b_i = r64b[CW-1:0];
                    c_carry_i = 1'($urandom_range(0, 1)); c_sub_i = 1'($urandom_range(0, 1));
                    #1;
                    if (c_valid_o && c_ready_i) begin
                        if (c_sb.size() == 0) unexp_n++;
                        else begin
                            exp = c_sb.pop_front();
                            n_checks++;
                            if ({c_overflow_o, c_carry_o, c_sum_o} !== exp || c_zero_o !== (exp[CW-1:0] == '0)) begin
                                n_fail++;
                                $display("FAIL cfg%0d_result: got %h z=%b want %h", gi, {c_overflow_o, c_carry_o, c_sum_o}, c_zero_o, exp);
                            end
                        end
                        if (first < 0) first = i;
                        else if (i != last + 1) gaps++;
                        last = i;
                        pops++;
                    end
                    if (c_valid_i && c_ready_o) c_sb.push_back(c_ref(c_a_i, c_b_i, c_carry_i, c_sub_i));
                end
                @(negedge clk);
                c_valid_i = 1'b0;
                n_checks++; if (pops != 100) begin n_fail++; $display("FAIL cfg%0d_count: got %0d want 100", gi, pops); end
                n_checks++; if (gaps != 0 || unexp_n != 0) begin n_fail++; $display("FAIL cfg%0d_gaps: got gaps=%0d extra=%0d want 0 0", gi, gaps, unexp_n); end
                n_checks++; if (first != CS) begin n_fail++; $display("FAIL cfg%0d_latency: got %0d want %0d", gi, first, CS); end
            endtask
        end
    endgenerate

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stall();
        test_reset_in_flight();
        g_cfg[0].test_b2b_cfg();
        g_cfg[1].test_b2b_cfg();
        g_cfg[2].test_b2b_cfg();
        g_cfg[3].test_b2b_cfg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
